// File: rtl/retire_monitor.sv
// Passive commit-side monitor: counts retires/cycles, buffers retired PCs in a
// trace FIFO, and flags program halt (PC self-loop), retire stalls and bad PCs.
module retire_monitor #(
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_debug,
  input  logic        i_insn_vld,
  input  logic        i_trace_rdy,
  output logic [31:0] o_trace_pc,
  output logic        o_trace_vld,
  output logic        o_overflow,
  output logic [31:0] o_retire_cnt,
  output logic [31:0] o_cycle_cnt,
  output logic        o_halt,
  output logic        o_error,
  output logic [1:0]  o_err_code
);

  localparam int unsigned AW = $clog2(TRACE_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]  state, state_n;
  logic [1:0]  code_n;
  logic [31:0] prev_pc;
  logic [31:0] rep_cnt, rep_n;
  logic [31:0] stall_cnt, stall_n;

  logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n, rd_plus;
  logic [31:0] mem [TRACE_DEPTH];
  logic [31:0] head_n;
  logic        live, push, pop, full, do_push;

  assign live    = (state == IDLE) || (state == RUN);
  assign push    = i_insn_vld && live;
  assign pop     = o_trace_vld && i_trace_rdy;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || pop);
  assign rd_plus = rd_ptr + (AW+1)'(1);
  assign wr_n    = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_n    = pop ? rd_plus : rd_ptr;

  // Registered head: next-cycle view of the FIFO front, bypassing the new PC when it lands at the head.
  always_comb begin
    head_n = o_trace_pc;
    if (pop) begin
      if (do_push && (rd_plus == wr_ptr)) head_n = i_pc_debug;
      else                                head_n = mem[rd_plus[AW-1:0]];
    end else if (do_push && (wr_ptr == rd_ptr)) begin
      head_n = i_pc_debug;
    end
  end

  always_comb begin
    state_n = state;
    code_n  = o_err_code;
    rep_n   = rep_cnt;
    stall_n = stall_cnt;
    case (state)
      IDLE, RUN: begin
        if (i_insn_vld) begin
          stall_n = '0;
          rep_n   = ((state == RUN) && (i_pc_debug == prev_pc)) ? rep_cnt + 32'd1 : 32'd1;
          if (i_pc_debug[1:0] != 2'b00) begin
            state_n = ERR;
            code_n  = 2'd1;
          end else if (rep_n == HALT_REPEAT) begin
            state_n = HALT;
          end else begin
            state_n = RUN;
          end
        end else if (state == RUN) begin
          stall_n = stall_cnt + 32'd1;
          if (stall_n == STALL_LIMIT) begin
            state_n = ERR;
            code_n  = 2'd2;
          end
        end
      end
      HALT: begin
        if (i_insn_vld && (i_pc_debug != prev_pc)) begin
          state_n = ERR;
          code_n  = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      prev_pc      <= '0;
      rep_cnt      <= '0;
      stall_cnt    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_trace_pc   <= '0;
      o_trace_vld  <= 1'b0;
      o_overflow   <= 1'b0;
      o_retire_cnt <= '0;
      o_cycle_cnt  <= '0;
      o_halt       <= 1'b0;
      o_error      <= 1'b0;
      o_err_code   <= '0;
    end else begin
      state       <= state_n;
      o_err_code  <= code_n;
      rep_cnt     <= rep_n;
      stall_cnt   <= stall_n;
      o_cycle_cnt <= o_cycle_cnt + 32'd1;
      if (push) begin
        prev_pc      <= i_pc_debug;
        o_retire_cnt <= o_retire_cnt + 32'd1;
      end
      if (push && full && !pop) o_overflow <= 1'b1;
      wr_ptr      <= wr_n;
      rd_ptr      <= rd_n;
      o_trace_vld <= (wr_n != rd_n);
      o_trace_pc  <= head_n;
      o_halt      <= (state_n == HALT);
      o_error     <= (state_n == ERR);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_reset) mem[wr_ptr[AW-1:0]] <= i_pc_debug;
  end

endmodule
